// File: rtl/vend_coin_ctrl.sv
// vend_coin_ctrl
// Coin-intake and dispense controller for the newspaper vending path.
// Two coin slots share one intake with round-robin fairness. Credit builds
// up against a programmable price. A dispense-motor handshake follows, then
// change or a timeout refund goes out through a separate return handshake.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   i_coin_a_valid/i_coin_a slot A coin present / code (01=5c, 10=10c)
//   o_coin_a_ready          slot A coin taken this cycle
//   i_coin_b_valid/i_coin_b slot B, same as slot A
//   o_coin_b_ready          slot B coin taken this cycle
//   o_coin_reject           one-cycle pulse after an invalid code is taken
//   o_dispense_req          request to dispense motor
//   i_dispense_ack          motor done
//   o_change_valid          change or refund pending
//   o_change_amt            cents to return, stable while o_change_valid
//   i_change_ack            coin return done
//   o_refund                pending return is a timeout refund
//   o_credit                current credit in cents
//   o_busy                  controller not idle
module vend_coin_ctrl #(
  parameter int PRICE    = 15,
  parameter int TIMEOUT  = 255,
  parameter int CREDIT_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_coin_a_valid,
  input  logic [1:0]          i_coin_a,
  output logic                o_coin_a_ready,
  input  logic                i_coin_b_valid,
  input  logic [1:0]          i_coin_b,
  output logic                o_coin_b_ready,
  output logic                o_coin_reject,
  output logic                o_dispense_req,
  input  logic                i_dispense_ack,
  output logic                o_change_valid,
  output logic [CREDIT_W-1:0] o_change_amt,
  input  logic                i_change_ack,
  output logic                o_refund,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COLLECT  = 3'd1;
  localparam logic [2:0] ST_DISPENSE = 3'd2;
  localparam logic [2:0] ST_CHANGE   = 3'd3;
  localparam logic [2:0] ST_REFUND   = 3'd4;

  // The timeout counter only needs to count 0..TIMEOUT-1; the refund
  // decision is taken on the cycle it sits at its last value.
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0]   TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

  logic [2:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_rr_b;
  logic                r_reject;

  logic                w_open;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_xfer;
  logic [1:0]          w_code;
  logic                w_code_ok;
  logic [CREDIT_W-1:0] w_value;
  logic [CREDIT_W-1:0] w_sum;
  logic [CREDIT_W-1:0] w_remain;

  // Intake is closed while reset is asserted so a source never sees its coin
  // taken on a cycle whose transfer reset then discards.
  assign w_open    = !reset && ((r_state == ST_IDLE) || (r_state == ST_COLLECT));
  // A lone valid slot always wins; with both valid, r_rr_b picks the slot.
  assign w_grant_a = i_coin_a_valid && (!i_coin_b_valid || !r_rr_b);
  assign w_grant_b = i_coin_b_valid && (!i_coin_a_valid ||  r_rr_b);

  assign o_coin_a_ready = w_open && w_grant_a;
  assign o_coin_b_ready = w_open && w_grant_b;

  assign w_xfer    = o_coin_a_ready || o_coin_b_ready;
  assign w_code    = o_coin_a_ready ? i_coin_a : i_coin_b;
  assign w_code_ok = (w_code == 2'b01) || (w_code == 2'b10);
  assign w_value   = (w_code == 2'b10) ? CREDIT_W'(10) : CREDIT_W'(5);
  assign w_sum     = r_credit + w_value;
  assign w_remain  = r_credit - PRICE_C;

  assign o_coin_reject  = r_reject;
  assign o_dispense_req = (r_state == ST_DISPENSE);
  assign o_change_valid = (r_state == ST_CHANGE) || (r_state == ST_REFUND);
  assign o_refund       = (r_state == ST_REFUND);
  // In CHANGE the credit already holds the remainder after the price was
  // taken, and in REFUND it holds the whole deposit, so credit is the amount.
  assign o_change_amt   = o_change_valid ? r_credit : '0;
  assign o_credit       = r_credit;
  assign o_busy         = (r_state != ST_IDLE);

  // Main sequencer: coin intake and timeout in IDLE/COLLECT, then the
  // dispense handshake, then the change/refund handshake back to IDLE.
  // An invalid coin is swallowed without touching credit, state or timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_tcnt   <= '0;
      r_rr_b   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= w_xfer && !w_code_ok;
      if (w_xfer) begin
        r_rr_b <= o_coin_a_ready;
      end
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_xfer && w_code_ok) begin
            r_credit <= w_sum;
            r_tcnt   <= '0;
            r_state  <= (w_sum >= PRICE_C) ? ST_DISPENSE : ST_COLLECT;
          end else if ((r_state == ST_COLLECT) && !w_xfer) begin
            if (r_tcnt == TCNT_LAST) begin
              r_tcnt  <= '0;
              r_state <= ST_REFUND;
            end else begin
              r_tcnt <= r_tcnt + TCNT_W'(1);
            end
          end
        end
        ST_DISPENSE: begin
          if (i_dispense_ack) begin
            r_credit <= w_remain;
            r_state  <= (w_remain != '0) ? ST_CHANGE : ST_IDLE;
          end
        end
        ST_CHANGE, ST_REFUND: begin
          if (i_change_ack) begin
            r_credit <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_coin_ctrl.sv
// tb_vend_coin_ctrl
// Self-checking bench for vend_coin_ctrl with PRICE=15 and TIMEOUT=8.
// A purchase-level model follows the coin/credit rules and is compared
// against every DUT output on each falling edge. Directed scenarios also
// pin hand-computed literal values at the points of interest.
module tb_vend_coin_ctrl;

  localparam int PRICE    = 15;
  localparam int TIMEOUT  = 8;
  localparam int CREDIT_W = 5;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                coinAValid = 1'b0;
  logic [1:0]          coinA = 2'b00;
  logic                coinBValid = 1'b0;
  logic [1:0]          coinB = 2'b00;
  logic                dispenseAck = 1'b0;
  logic                changeAck = 1'b0;
  logic                coinAReady;
  logic                coinBReady;
  logic                coinReject;
  logic                dispenseReq;
  logic                changeValid;
  logic [CREDIT_W-1:0] changeAmt;
  logic                refundOut;
  logic [CREDIT_W-1:0] creditOut;
  logic                busyOut;

  vend_coin_ctrl #(
    .PRICE(PRICE),
    .TIMEOUT(TIMEOUT),
    .CREDIT_W(CREDIT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_coin_a_valid(coinAValid),
    .i_coin_a(coinA),
    .o_coin_a_ready(coinAReady),
    .i_coin_b_valid(coinBValid),
    .i_coin_b(coinB),
    .o_coin_b_ready(coinBReady),
    .o_coin_reject(coinReject),
    .o_dispense_req(dispenseReq),
    .i_dispense_ack(dispenseAck),
    .o_change_valid(changeValid),
    .o_change_amt(changeAmt),
    .i_change_ack(changeAck),
    .o_refund(refundOut),
    .o_credit(creditOut),
    .o_busy(busyOut)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Purchase-level model: where we are in the purchase, how much money is
  // in the machine, how long the customer has been quiet, and whose turn it
  // is when both slots offer a coin.
  typedef enum {M_IDLE, M_COLLECT, M_DISPENSE, M_CHANGE, M_REFUND} phase_t;
  phase_t mPhase  = M_IDLE;
  int     mCredit = 0;
  int     mQuiet  = 0;
  bit     mTurnB  = 1'b0;
  bit     mReject = 1'b0;
  bit     takeA, takeB;
  int     coinCents;

  function automatic bit mayTake(input bit slotB);
    if (reset || !(mPhase == M_IDLE || mPhase == M_COLLECT)) return 1'b0;
    if (slotB) return coinBValid && (!coinAValid || mTurnB);
    return coinAValid && (!coinBValid || !mTurnB);
  endfunction

  function automatic int centsOf(input logic [1:0] code);
    if (code == 2'b01) return 5;
    if (code == 2'b10) return 10;
    return 0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mPhase  = M_IDLE;
      mCredit = 0;
      mQuiet  = 0;
      mTurnB  = 1'b0;
      mReject = 1'b0;
    end else begin
      takeA   = mayTake(1'b0);
      takeB   = mayTake(1'b1);
      mReject = 1'b0;
      if (takeA || takeB) begin
        coinCents = centsOf(takeA ? coinA : coinB);
        mTurnB    = takeA;
        if (coinCents == 0) begin
          mReject = 1'b1;
        end else begin
          mCredit = mCredit + coinCents;
          mQuiet  = 0;
          mPhase  = (mCredit >= PRICE) ? M_DISPENSE : M_COLLECT;
        end
      end else if (mPhase == M_COLLECT) begin
        mQuiet++;
        if (mQuiet == TIMEOUT) begin
          mQuiet = 0;
          mPhase = M_REFUND;
        end
      end else if (mPhase == M_DISPENSE && dispenseAck) begin
        mCredit = mCredit - PRICE;
        mPhase  = (mCredit > 0) ? M_CHANGE : M_IDLE;
      end else if ((mPhase == M_CHANGE || mPhase == M_REFUND) && changeAck) begin
        mCredit = 0;
        mPhase  = M_IDLE;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("coin_a_ready", coinAReady, mayTake(1'b0));
      checkOutput("coin_b_ready", coinBReady, mayTake(1'b1));
      checkOutput("coin_reject", coinReject, mReject);
      checkOutput("dispense_req", dispenseReq, mPhase == M_DISPENSE);
      checkOutput("change_valid", changeValid, mPhase == M_CHANGE || mPhase == M_REFUND);
      checkOutput("refund", refundOut, mPhase == M_REFUND);
      checkOutput("change_amt", changeAmt,
                  (mPhase == M_CHANGE || mPhase == M_REFUND) ? mCredit : 0);
      checkOutput("credit", creditOut, mCredit);
      checkOutput("busy", busyOut, mPhase != M_IDLE);
    end
  end

  // One call drives the inputs for one whole clock cycle.
  task automatic applyStimulus(input bit aV, input logic [1:0] a, input bit bV,
                               input logic [1:0] b, input bit dAck, input bit cAck);
    @(posedge clock);
    #1;
    coinAValid  = aV;
    coinA       = a;
    coinBValid  = bV;
    coinB       = b;
    dispenseAck = dAck;
    changeAck   = cAck;
  endtask

  task automatic pulseReset();
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset credit", creditOut, 0);
    checkOutput("reset busy", busyOut, 0);
    checkOutput("reset dispense_req", dispenseReq, 0);
    checkOutput("reset change_valid", changeValid, 0);
  endtask

  initial begin
    @(posedge clock);
    #1;
    reset   = 1'b0;
    checkEn = 1'b1;
    @(negedge clock);
    checkOutput("initial credit", creditOut, 0);
    checkOutput("initial busy", busyOut, 0);
    checkOutput("initial coin_reject", coinReject, 0);

    // Exact price from slot A, ack on the first dispense cycle.
    pulseReset();
    applyStimulus(1, 2'b10, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s1 a_ready 10c", coinAReady, 1);
    applyStimulus(1, 2'b01, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s1 credit 10", creditOut, 10);
    applyStimulus(0, 2'b00, 0, 2'b00, 1, 0);
    @(negedge clock); checkOutput("s1 dispense_req", dispenseReq, 1);
    checkOutput("s1 credit 15", creditOut, 15);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s1 dispense_req low", dispenseReq, 0);
    checkOutput("s1 credit 0", creditOut, 0);
    checkOutput("s1 idle", busyOut, 0);

    // Overpay 20c, 5c change.
    pulseReset();
    applyStimulus(1, 2'b10, 0, 2'b00, 0, 0);
    applyStimulus(1, 2'b10, 0, 2'b00, 0, 0);
    applyStimulus(0, 2'b00, 0, 2'b00, 1, 0);
    @(negedge clock); checkOutput("s2 credit 20", creditOut, 20);
    checkOutput("s2 dispense_req", dispenseReq, 1);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 1);
    @(negedge clock); checkOutput("s2 change_valid", changeValid, 1);
    checkOutput("s2 change_amt", changeAmt, 5);
    checkOutput("s2 refund", refundOut, 0);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s2 credit 0", creditOut, 0);
    checkOutput("s2 idle", busyOut, 0);

    // Both slots offering 5c: A, B, A, then blocked, then B first.
    pulseReset();
    applyStimulus(1, 2'b01, 1, 2'b01, 0, 0);
    @(negedge clock); checkOutput("s3 g1 a", coinAReady, 1); checkOutput("s3 g1 b", coinBReady, 0);
    applyStimulus(1, 2'b01, 1, 2'b01, 0, 0);
    @(negedge clock); checkOutput("s3 g2 a", coinAReady, 0); checkOutput("s3 g2 b", coinBReady, 1);
    applyStimulus(1, 2'b01, 1, 2'b01, 0, 0);
    @(negedge clock); checkOutput("s3 g3 a", coinAReady, 1); checkOutput("s3 g3 b", coinBReady, 0);
    applyStimulus(1, 2'b01, 1, 2'b01, 1, 0);
    @(negedge clock); checkOutput("s3 blocked a", coinAReady, 0); checkOutput("s3 blocked b", coinBReady, 0);
    checkOutput("s3 dispense_req", dispenseReq, 1);
    applyStimulus(1, 2'b01, 1, 2'b01, 0, 0);
    @(negedge clock); checkOutput("s3 after a", coinAReady, 0); checkOutput("s3 after b", coinBReady, 1);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);

    // Invalid code in IDLE.
    pulseReset();
    applyStimulus(1, 2'b11, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s4 a_ready", coinAReady, 1); checkOutput("s4 no reject yet", coinReject, 0);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s4 reject", coinReject, 1);
    checkOutput("s4 credit", creditOut, 0); checkOutput("s4 idle", busyOut, 0);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s4 reject one cycle", coinReject, 0);

    // Timeout refund after 8 quiet COLLECT cycles.
    pulseReset();
    applyStimulus(1, 2'b01, 0, 2'b00, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
      @(negedge clock); checkOutput("s5 still collecting", changeValid, 0);
      checkOutput("s5 busy", busyOut, 1);
    end
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 1);
    @(negedge clock); checkOutput("s5 change_valid", changeValid, 1);
    checkOutput("s5 refund", refundOut, 1); checkOutput("s5 change_amt", changeAmt, 5);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s5 refund done", refundOut, 0); checkOutput("s5 idle", busyOut, 0);

    // Reset while dispensing, then a stray ack.
    pulseReset();
    applyStimulus(1, 2'b10, 0, 2'b00, 0, 0);
    applyStimulus(1, 2'b01, 0, 2'b00, 0, 0);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    reset = 1'b1;
    @(negedge clock); checkOutput("s6 dispensing", dispenseReq, 1);
    applyStimulus(0, 2'b00, 0, 2'b00, 1, 0);
    reset = 1'b0;
    @(negedge clock); checkOutput("s6 dispense_req 0", dispenseReq, 0);
    checkOutput("s6 credit 0", creditOut, 0); checkOutput("s6 idle", busyOut, 0);
    applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    @(negedge clock); checkOutput("s6 ack ignored credit", creditOut, 0);
    checkOutput("s6 ack ignored busy", busyOut, 0);

    repeat (3) applyStimulus(0, 2'b00, 0, 2'b00, 0, 0);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vend_coin_ctrl.md
# vend_coin_ctrl

Coin-intake and dispense controller for the newspaper vending path. It arbitrates between two physical coin slots with round-robin fairness and accumulates credit against a programmable price. It sequences the dispense-motor handshake and returns change or a timeout refund through a separate handshake. It replaces the fixed-price, single-slot, change-less sequencing of the basic vend FSM.

## Interface
- PRICE, 15: item price in cents; multiple of 5, ≥ 5.
- TIMEOUT, 255: idle cycles in COLLECT before refund; ≥ 1.
- CREDIT_W, 5: credit/change width; must hold PRICE+5.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- coin_a_valid  in  1  slot A coin present
- coin_a  in  2  slot A code: 01=5c, 10=10c, 00/11 invalid
- coin_a_ready  out  1  slot A coin taken this cycle
- coin_b_valid, coin_b, coin_b_ready: same as slot A, for slot B
- coin_reject  out  1  one-cycle pulse: invalid code taken and returned
- dispense_req  out  1  request to dispense motor
- dispense_ack  in  1  motor done
- change_valid  out  1  change/refund pending
- change_amt  out  CREDIT_W  cents to return; stable while change_valid
- change_ack  in  1  coin return done
- refund  out  1  change_valid is a timeout refund, not change
- credit  out  CREDIT_W  current credit in cents
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE, REFUND.
- Reset values: state IDLE, credit 0, timeout counter 0, RR pointer to slot A. All outputs are 0.
- Intake is open only in IDLE/COLLECT.
  - Only one slot is granted per cycle. With one valid slot, that slot is granted; with both valid, the RR pointer's slot is granted.
  - ready = intake open AND granted AND valid. Transfer = valid && ready.
  - After a transfer from slot X, the pointer moves to the other slot. It holds otherwise.
- Valid-code transfer: credit ← credit + value.
  - IDLE → COLLECT if the new credit < PRICE, else → DISPENSE.
  - COLLECT → DISPENSE if the new credit ≥ PRICE.
- Invalid-code transfer: the coin is consumed and coin_reject pulses next cycle. Credit, state and timeout counter are unchanged.
- COLLECT timeout:
  - The counter clears on any valid-code transfer and increments on every other COLLECT cycle.
  - When the counter reaches TIMEOUT, go to REFUND with change_amt = credit.
- DISPENSE: dispense_req = 1.
  - On dispense_ack, credit ← credit − PRICE.
  - If the remainder > 0, go to CHANGE with change_amt = remainder; else go to IDLE.
- CHANGE/REFUND: change_valid = 1; refund = 1 only in REFUND. On change_ack, credit ← 0 and go to IDLE.
- Arithmetic: credit never exceeds PRICE+5 and never underflows, so no wrap occurs.
- dispense_ack outside DISPENSE and change_ack outside CHANGE/REFUND are ignored.

## Timing
- ready is combinational from state, valids and the RR pointer (same cycle). Coin sources hold code and valid until ready.
- credit and state update on the edge ending the transfer cycle.
- Coin reaching PRICE: dispense_req is high the next cycle. It holds until the ack cycle and is low the cycle after.
- An ack asserted in the first DISPENSE/CHANGE/REFUND cycle is valid, giving a minimum one-cycle handshake.
- Refund asserts after exactly TIMEOUT consecutive COLLECT cycles without a valid coin.
- Coins presented during DISPENSE/CHANGE/REFUND see ready = 0 and wait. They are granted in the first IDLE cycle.
- Reset mid-operation (any state) returns to IDLE the next cycle: dispense_req, change_valid, refund and credit go to 0. In-flight credit is discarded.
- Reset has priority over a coincident transfer or ack.

## Test plan
- PRICE=15, TIMEOUT=8 for all scenarios.
- Slot A 10c then 5c, ack the cycle dispense_req rises → dispense_req high 1 cycle after the 2nd transfer; credit 0; IDLE; change_valid never 1.
- A 10c, A 10c → credit 20, DISPENSE; dispense_ack → CHANGE, change_amt=5, refund=0; change_ack → IDLE, credit 0.
- Both slots valid with 5c continuously → ready order A,B,A, one per cycle; then DISPENSE with both ready 0; after ack, next grant is B.
- A code 11 in IDLE → coin_a_ready=1, coin_reject pulse next cycle, credit 0, state IDLE.
- A 5c, then no coins → REFUND after 8 COLLECT cycles: change_valid=1, refund=1, change_amt=5; change_ack → IDLE.
- Reset during DISPENSE → next cycle IDLE, dispense_req 0, credit 0; a later dispense_ack has no effect.
